// File: rtl/seqgen_multi.sv
// Multi-mode sequence generator: up, down, Gray, Johnson or maximal-length LFSR
// on a single WIDTH-bit register, with synchronous load and a registered wrap pulse.
module seqgen_multi #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SEED  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             wrap
);

  localparam logic [2:0] MODE_UP      = 3'b000;
  localparam logic [2:0] MODE_DOWN    = 3'b001;
  localparam logic [2:0] MODE_GRAY    = 3'b010;
  localparam logic [2:0] MODE_JOHNSON = 3'b011;
  localparam logic [2:0] MODE_LFSR    = 3'b100;

  // Fibonacci tap masks (bit n-1 set for 1-based tap n), maximal length per width.
  function automatic logic [15:0] tap_mask(input int unsigned w);
    logic [15:0] m;
    m = 16'h0000;
    case (w)
      2:       m = 16'h0003;
      3:       m = 16'h0006;
      4:       m = 16'h000C;
      5:       m = 16'h0014;
      6:       m = 16'h0030;
      7:       m = 16'h0060;
      8:       m = 16'h00B8;
      9:       m = 16'h0110;
      10:      m = 16'h0240;
      11:      m = 16'h0500;
      12:      m = 16'h0829;
      13:      m = 16'h100D;
      14:      m = 16'h2015;
      15:      m = 16'h6000;
      16:      m = 16'hD008;
      default: m = 16'h0000;
    endcase
    return m;
  endfunction

  localparam logic [WIDTH-1:0] TAPS   = WIDTH'(tap_mask(WIDTH));
  localparam logic [WIDTH-1:0] SEED_W = WIDTH'(SEED);

  logic [WIDTH-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] gray_bin, gray_inc;
  logic [WIDTH-1:0] next_val, start_val;
  logic             mode_legal;

  // Next value and start value for the selected sequence.
  always_comb begin
    gray_bin   = out_q;
    gray_inc   = '0;
    next_val   = out_q;
    start_val  = '0;
    mode_legal = 1'b1;

    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      gray_bin[i] = gray_bin[i+1] ^ out_q[i];
    end
    gray_inc = gray_bin + WIDTH'(1);

    case (mode)
      MODE_UP: begin
        next_val  = out_q + WIDTH'(1);
        start_val = '0;
      end
      MODE_DOWN: begin
        next_val  = out_q - WIDTH'(1);
        start_val = '1;
      end
      MODE_GRAY: begin
        next_val  = gray_inc ^ (gray_inc >> 1);
        start_val = '0;
      end
      MODE_JOHNSON: begin
        next_val  = {out_q[WIDTH-2:0], ~out_q[WIDTH-1]};
        start_val = '0;
      end
      MODE_LFSR: begin
        // All-zero is the LFSR lock-up state; recover straight to the seed.
        next_val  = (out_q == '0) ? SEED_W : {out_q[WIDTH-2:0], ^(out_q & TAPS)};
        start_val = SEED_W;
      end
      default: begin
        next_val   = out_q;
        mode_legal = 1'b0;
      end
    endcase
  end

  // Edge priority: load over advance over hold.
  always_comb begin
    out_d  = out_q;
    wrap_d = 1'b0;
    if (load) begin
      out_d = load_val;
    end else if (en && mode_legal) begin
      out_d  = next_val;
      wrap_d = (next_val == start_val);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign out  = out_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_seqgen_multi.sv
// Self-checking bench for seqgen_multi (WIDTH=4): directed sequence tables plus
// randomized traffic compared against an arithmetic reference model.
module tb_seqgen_multi;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;
  localparam int SEED = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [2:0]   mode = 3'b000;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] out;
  logic         wrap;

  int checks = 0;
  int failures = 0;
  int m_out = 0;
  int m_wrap = 0;

  int tap_tbl [2:16][4] = '{'{2,1,0,0}, '{3,2,0,0}, '{4,3,0,0}, '{5,3,0,0}, '{6,5,0,0},
                            '{7,6,0,0}, '{8,6,5,4}, '{9,5,0,0}, '{10,7,0,0}, '{11,9,0,0},
                            '{12,6,4,1}, '{13,4,3,1}, '{14,5,3,1}, '{15,14,0,0},
                            '{16,15,13,4}};

  seqgen_multi #(.WIDTH(W), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
    .load_val(load_val), .out(out), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic int start_of(input int md);
    case (md)
      1:       return MASK;
      4:       return SEED;
      default: return 0;
    endcase
  endfunction

  function automatic int next_of(input int v, input int md);
    int b, fb;
    case (md)
      0: return (v + 1) & MASK;
      1: return (v - 1) & MASK;
      2: begin
        b = v;
        for (int s = 1; s < W; s = s * 2) b = b ^ (b >> s);
        b = (b + 1) & MASK;
        return b ^ (b >> 1);
      end
      3: return ((v << 1) & MASK) | (((v >> (W - 1)) & 1) ^ 1);
      4: begin
        if (v == 0) return SEED;
        fb = 0;
        for (int k = 0; k < 4; k++)
          if (tap_tbl[W][k] != 0) fb = fb ^ ((v >> (tap_tbl[W][k] - 1)) & 1);
        return ((v << 1) & MASK) | fb;
      end
      default: return v;
    endcase
  endfunction

  // One rising edge: update the model from the current inputs, then let the DUT clock.
  task automatic step();
    int n;
    if (rst) begin
      m_out = 0; m_wrap = 0;
    end else if (load) begin
      m_out = int'(load_val); m_wrap = 0;
    end else if (en && mode <= 3'd4) begin
      n = next_of(m_out, int'(mode));
      m_wrap = (n == start_of(int'(mode))) ? 1 : 0;
      m_out = n;
    end else begin
      m_wrap = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    m_out = 0; m_wrap = 0;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 3'b000;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (out !== 4'h0 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset: out=%h wrap=%b, want out=0 wrap=0", out, wrap);
    end
    rst = 1'b0;
  endtask

  task automatic test_up();
    int exp_o, exp_w;
    mode = 3'b000; en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      step();
      exp_o = (i + 1) & MASK;
      exp_w = (i == 15) ? 1 : 0;
      checks++;
      if (out !== W'(exp_o) || wrap !== 1'(exp_w)) begin
        failures++;
        $display("FAIL up step %0d: out=%h wrap=%b, want out=%h wrap=%0d", i, out, wrap, exp_o, exp_w);
      end
    end
  endtask

  task automatic test_gray();
    int exp_g[8] = '{1, 3, 2, 6, 7, 5, 4, 12};
    pulse_reset();
    mode = 3'b010; en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      if (i < 8) begin
        checks++;
        if (out !== W'(exp_g[i])) begin
          failures++;
          $display("FAIL gray step %0d: out=%h, want %h", i, out, exp_g[i]);
        end
      end
      checks++;
      if (wrap !== ((i == 15) ? 1'b1 : 1'b0)) begin
        failures++;
        $display("FAIL gray wrap step %0d: wrap=%b, want %0d", i, wrap, (i == 15));
      end
    end
    checks++;
    if (out !== 4'h0) begin
      failures++;
      $display("FAIL gray period end: out=%h, want 0", out);
    end
    load = 1'b1; load_val = 4'h0;
    step();
    load = 1'b0; mode = 3'b001;
    step();
    checks++;
    if (out !== 4'hF || wrap !== 1'b1) begin
      failures++;
      $display("FAIL down from 0: out=%h wrap=%b, want out=F wrap=1", out, wrap);
    end
  endtask

  task automatic test_johnson();
    int exp_j[8] = '{1, 3, 7, 15, 14, 12, 8, 0};
    pulse_reset();
    mode = 3'b011; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (out !== W'(exp_j[i]) || wrap !== ((i == 7) ? 1'b1 : 1'b0)) begin
        failures++;
        $display("FAIL johnson step %0d: out=%h wrap=%b, want out=%h wrap=%0d", i, out, wrap, exp_j[i], (i == 7));
      end
    end
  endtask

  task automatic test_lfsr();
    int exp_l[16] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8, 1};
    pulse_reset();
    mode = 3'b100; en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (out !== W'(exp_l[i]) || wrap !== ((i == 0 || i == 15) ? 1'b1 : 1'b0)) begin
        failures++;
        $display("FAIL lfsr step %0d: out=%h wrap=%b, want out=%h wrap=%0d", i, out, wrap, exp_l[i], (i == 0 || i == 15));
      end
    end
  endtask

  task automatic test_hold_load_reserved();
    logic [W-1:0] held;
    held = out;
    mode = 3'b000; en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (out !== held || wrap !== 1'b0) begin
        failures++;
        $display("FAIL hold step %0d: out=%h wrap=%b, want out=%h wrap=0", i, out, wrap, held);
      end
    end
    load = 1'b1; en = 1'b1; load_val = 4'hA;
    step();
    load = 1'b0;
    checks++;
    if (out !== 4'hA || wrap !== 1'b0) begin
      failures++;
      $display("FAIL load: out=%h wrap=%b, want out=A wrap=0", out, wrap);
    end
    mode = 3'b110;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (out !== 4'hA || wrap !== 1'b0) begin
        failures++;
        $display("FAIL reserved step %0d: out=%h wrap=%b, want out=A wrap=0", i, out, wrap);
      end
    end
    mode = 3'b000;
    step();
    checks++;
    if (out !== 4'hB) begin
      failures++;
      $display("FAIL mode switch: out=%h, want B", out);
    end
  endtask

  task automatic test_async_reset();
    pulse_reset();
    mode = 3'b000; en = 1'b1;
    for (int i = 0; i < 7; i++) step();
    checks++;
    if (out !== 4'h7) begin
      failures++;
      $display("FAIL pre-reset count: out=%h, want 7", out);
    end
    #2 rst = 1'b1;
    m_out = 0; m_wrap = 0;
    #1;
    checks++;
    if (out !== 4'h0 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL async reset: out=%h wrap=%b, want out=0 wrap=0", out, wrap);
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (out !== W'(i + 1)) begin
        failures++;
        $display("FAIL resume step %0d: out=%h, want %h", i, out, i + 1);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) mode = 3'($urandom_range(0, 7));
      en = ($urandom_range(0, 9) < 8);
      load = ($urandom_range(0, 19) == 0);
      load_val = W'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      step();
      checks++;
      if (out !== W'(m_out) || wrap !== 1'(m_wrap)) begin
        failures++;
        $display("FAIL random cycle %0d mode %0d: out=%h wrap=%b, want out=%h wrap=%0d",
                 i, mode, out, wrap, m_out, m_wrap);
      end
    end
    rst = 1'b0; load = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_up();
    test_gray();
    test_johnson();
    test_lfsr();
    test_hold_load_reserved();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seqgen_multi.md
Name: seqgen_multi

Overview:
Parametrised multi-mode sequence generator. It is the successor to the fixed 4-bit, single-sequence generator. One state register of WIDTH bits advances on enable through one of five runtime-selectable sequences: binary up, binary down, Gray, Johnson or maximal-length LFSR. Adds synchronous load and a registered wrap pulse, so downstream counters and test logic can chain periods.

Parameters:
WIDTH, 4, state/output width; legal 2..16.
SEED, 1, LFSR start value and lock-up recovery value; must be nonzero in WIDTH bits.

Ports:
clk  input  1  sole clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  advance enable, sampled at rising clk
mode  input  3  sequence select (see Behaviour)
load  input  1  synchronous load strobe
load_val  input  WIDTH  value written on load
out  output  WIDTH  registered current sequence value
wrap  output  1  registered one-cycle pulse, out returned to start value

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset: out=0 and wrap=0 immediately on rst rising, independent of clk. Held while rst=1. First advance is on the first rising clk edge with rst=0.
- Priority per edge: rst > load > en > hold.
- load=1: out<=load_val and wrap<=0, regardless of en or mode, with no range check.
- en=0, load=0: out holds, wrap<=0.
- en=1, load=0: out<=next(out, mode), with a latency of one edge.
- Mode encoding and next-state:
  - 000 up: out+1 mod 2^WIDTH. Start value 0.
  - 001 down: out-1 mod 2^WIDTH. Start value all-ones.
  - 010 Gray: out is treated as a Gray code. Convert to binary b, compute b+1 mod 2^WIDTH, convert back with g=b^(b>>1). Start value 0.
  - 011 Johnson: {out[WIDTH-2:0], ~out[WIDTH-1]}. Start value 0. Period 2*WIDTH from 0.
  - 100 LFSR: Fibonacci, shift left, feedback into bit0. Feedback is the XOR of tap bits (1-based) from this table:
    - 2:{2,1}, 3:{3,2}, 4:{4,3}, 5:{5,3}, 6:{6,5}, 7:{7,6}, 8:{8,6,5,4}
    - 9:{9,5}, 10:{10,7}, 11:{11,9}, 12:{12,6,4,1}, 13:{13,4,3,1}, 14:{14,5,3,1}, 15:{15,14}, 16:{16,15,13,4}
    - Start value SEED. Period 2^WIDTH-1.
  - 101..111: reserved. out holds, wrap<=0, even with en=1.
- LFSR lock-up: in mode 100, an advance from out==0 (reset or load) gives out<=SEED, with wrap<=1.
- wrap:
  - wrap<=1 on an edge where an en-advance makes out equal the current mode's start value.
  - Otherwise wrap<=0.
  - Never set by reset, load or hold.
  - With continuous en, wrap is high exactly one cycle per period.
- Mode change mid-run: no state conversion. The next advance applies the new mode's function to the current out, with no bubble.
- Johnson from non-canonical states (loaded or after a mode switch) follows the same shift rule. The period is not guaranteed; this is correct behaviour.
- Gray from an arbitrary loaded value continues the Gray sequence from that value's binary equivalent.
- rst asserted mid-run: out and wrap clear asynchronously. Pending load/en are ignored until release.
- All arithmetic is unsigned WIDTH-bit with silent wrap. No internal state beyond out and wrap.

Test Plan:
- WIDTH=4, rst=1 with en=1 for 3 clocks -> out=0, wrap=0. Release, mode=000, en=1 for 16 edges -> out 1..15,0. wrap=1 only in the cycle out=0, then 0.
- mode=010 from reset, 8 edges -> out 1,3,2,6,7,5,4,C. After 16 edges out=0 with wrap=1. mode=001 from load 0 -> out=F, wrap=1.
- mode=011 from reset -> 1,3,7,F,E,C,8,0, with wrap=1 on the 8th edge only.
- mode=100 from reset (out=0) -> first edge gives 1 with wrap=1, then 2,4,9,3,6,D,A,5,B,7,F,E,C,8,1, with wrap on the return to 1 (period 15).
- Hold/load/reserved: en=0 for 5 edges -> out unchanged. load=1, en=1, load_val=A -> out=A, wrap=0. mode=110, en=1 -> out stays A. Switch to mode=000 -> B next edge.
- Async reset: mid-count at out=7, pulse rst between clock edges -> out=0 before the next edge. Counting resumes 1,2,... after release.
